// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
// Port ids are sized for the largest supported requester count.
package mem_arb_pkg;

    localparam int MAX_PORTS = 8;
    localparam int PORT_ID_W = $clog2(MAX_PORTS);

    typedef logic [PORT_ID_W-1:0] port_id_t;

    localparam logic [3:0] WB_READ = 4'b0000;
    localparam logic [3:0] WB_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wb;
        logic [31:0] data;
        port_id_t    id;
        logic        err;
    } mem_cmd_t;

    // True when a word access at addr would not fit entirely inside the window.
    function automatic logic out_of_window(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int          size);
        logic [33:0] a;
        logic [33:0] lo;
        logic [33:0] hi;
        a  = {2'b00, addr};
        lo = {2'b00, base};
        hi = lo + 34'(size) - 34'd3;
        return (a < lo) || (a >= hi);
    endfunction

endpackage

// File: rtl/interface_memory.sv
// Word-wide single-port memory bus: the arbiter drives it, the RAM answers it.
interface interface_memory;
    logic        enable_in;
    logic [3:0]  wb_in;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (output enable_in, output wb_in, output addr_in, output data_in, input data_out);
    modport slave  (input enable_in, input wb_in, input addr_in, input data_in, output data_out);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first eligible port at or after the pointer, found by
// masking a doubled request vector and taking its lowest set bit.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3
) (
    input  logic [NUM_PORTS-1:0] eligible,
    input  port_id_t             pointer,
    output logic [NUM_PORTS-1:0] grant,
    output port_id_t             winner,
    output logic                 grant_valid
);
    localparam int SPAN = 2 * NUM_PORTS;

    logic [SPAN-1:0] doubled;
    logic [SPAN-1:0] keep;
    logic [SPAN-1:0] masked;
    int              pick;

    assign doubled     = {eligible, eligible};
    assign masked      = doubled & keep;
    assign grant_valid = |eligible;

    genvar gi;
    generate
        for (gi = 0; gi < SPAN; gi++) begin : g_keep
            assign keep[gi] = (gi >= int'(pointer));
        end
    endgenerate

    // The upper copy is never masked, so any eligible port guarantees a hit.
    always_comb begin
        pick = SPAN - 1;
        for (int i = SPAN - 1; i >= 0; i--) begin
            if (masked[i]) begin
                pick = i;
            end
        end
    end

    assign winner = (pick >= NUM_PORTS) ? port_id_t'(pick - NUM_PORTS) : port_id_t'(pick);

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_grant
            assign grant[gi] = grant_valid && (winner == port_id_t'(gi));
        end
    endgenerate
endmodule

// File: rtl/single_port_ram.sv
// Byte-maskable word RAM; read data follows the address within the same cycle
// so the arbiter can capture it at the write-commit edge.
module single_port_ram #(
    parameter int SIZE = 65536
) (
    input logic             clock,
    interface_memory.slave  mem_if
);
    localparam int WORDS = SIZE / 4;
    localparam int IDX_W = $clog2(WORDS);

    logic [31:0]      mem [WORDS];
    logic [IDX_W-1:0] idx;
    logic             unused_addr_bits;

    assign idx              = mem_if.addr_in[IDX_W+1:2];
    assign unused_addr_bits = ^{mem_if.addr_in[31:IDX_W+2], mem_if.addr_in[1:0]};

    // wb_in bit b writes byte lane [8b+7:8b]; bit 3 is the lowest byte address.
    always_ff @(posedge clock) begin
        if (mem_if.enable_in) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_if.wb_in[b]) begin
                    mem[idx][8*b +: 8] <= mem_if.data_in[8*b +: 8];
                end
            end
        end
    end

    assign mem_if.data_out = mem[idx];
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM among NUM_PORTS requesters: grant, issue, ack
// in a three-stage pipeline with one outstanding command per port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          NUM_PORTS        = 3,
    parameter int          MEMORY_BUS_WIDTH = 32,
    parameter int          SIZE             = 65536,
    parameter logic [31:0] ADDRESS          = 32'h0000_0000
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUM_PORTS-1:0]                      req_i,
    input  logic [NUM_PORTS-1:0][3:0]                 wb_i,
    input  logic [NUM_PORTS-1:0][31:0]                addr_i,
    input  logic [NUM_PORTS-1:0][MEMORY_BUS_WIDTH-1:0] data_i,
    input  logic [NUM_PORTS-1:0]                      lock_i,
    output logic [NUM_PORTS-1:0]                      ack_o,
    output logic                                      err_o,
    output logic [MEMORY_BUS_WIDTH-1:0]               rdata_o,
    interface_memory.master                           mem_if
);
    port_id_t                    ptr_reg;
    port_id_t                    ptr_next;
    mem_cmd_t                    cmd_reg;
    mem_cmd_t                    cmd_next;
    logic                        cmd_valid_reg;
    logic [NUM_PORTS-1:0]        ack_reg;
    logic [NUM_PORTS-1:0]        ack_next;
    logic                        err_reg;
    logic [MEMORY_BUS_WIDTH-1:0] rdata_reg;

    logic [NUM_PORTS-1:0] inflight;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    port_id_t             winner;
    logic                 grant_valid;
    logic                 lock_win;

    // A port is busy while its command is issuing and while it is being acked.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign ack_next[gi] = cmd_valid_reg && (cmd_reg.id == port_id_t'(gi));
            assign inflight[gi] = ack_next[gi] || ack_reg[gi];
        end
    endgenerate

    assign eligible = req_i & ~inflight;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .eligible    (eligible),
        .pointer     (ptr_reg),
        .grant       (grant),
        .winner      (winner),
        .grant_valid (grant_valid)
    );

    always_comb begin
        cmd_next = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                cmd_next.addr = addr_i[i];
                cmd_next.wb   = wb_i[i];
                cmd_next.data = data_i[i];
            end
        end
        cmd_next.id  = winner;
        cmd_next.err = out_of_window(cmd_next.addr, ADDRESS, SIZE);

        // A locked winner keeps the pointer so its next request wins first.
        lock_win = |(lock_i & grant);
        ptr_next = ptr_reg;
        if (grant_valid) begin
            if (lock_win) begin
                ptr_next = winner;
            end else if (winner == port_id_t'(NUM_PORTS - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = winner + port_id_t'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_reg       <= '0;
            cmd_reg       <= '0;
            cmd_valid_reg <= 1'b0;
            ack_reg       <= '0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
        end else begin
            ptr_reg       <= ptr_next;
            cmd_valid_reg <= grant_valid;
            if (grant_valid) begin
                cmd_reg <= cmd_next;
            end
            ack_reg <= ack_next;
            err_reg <= cmd_valid_reg && cmd_reg.err;
            if (cmd_valid_reg) begin
                rdata_reg <= (!cmd_reg.err && cmd_reg.wb == WB_READ) ? mem_if.data_out : '0;
            end
        end
    end

    // cmd_valid is cleared asynchronously, so the RAM enable falls with reset.
    assign mem_if.enable_in = cmd_valid_reg && !cmd_reg.err;
    assign mem_if.addr_in   = cmd_reg.addr - ADDRESS;
    assign mem_if.wb_in     = cmd_reg.wb;
    assign mem_if.data_in   = cmd_reg.data;

    assign ack_o   = ack_reg;
    assign err_o   = err_reg;
    assign rdata_o = rdata_reg;
endmodule
